// File: rtl/down_counter_ctrl.sv
// ---------------------------------------------------------------------------
// down_counter_ctrl
//
// Load-and-run down counter with a three-state controller (IDLE, COUNT,
// DONE). A start request in IDLE captures ld_val and begins counting; each
// qualified tick (cen & clkEn) decrements the count until it reaches zero.
// The tick seen at zero ends the run with a one-clock done pulse, and the
// controller then returns to IDLE. The count never wraps below zero.
//
// Ports
//   clk     in   sole clock, rising edge
//   rst     in   asynchronous reset, active low
//   rst_cu  in   synchronous clear/abort, active high, highest priority
//   start   in   load-and-run request, sampled only in IDLE
//   ld_val  in   [WIDTH-1:0] start value, captured together with start
//   cen     in   count enable
//   clkEn   in   tick qualifier; a tick is cen & clkEn at a rising edge
//   cnt     out  [WIDTH-1:0] current count (registered)
//   bo      out  borrow-out, high while counting with cnt == 0
//   busy    out  high whenever the controller is not idle
//   done    out  one-clock completion pulse
// ---------------------------------------------------------------------------
module down_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_cu,
  input  logic             start,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             cen,
  input  logic             clkEn,
  output logic [WIDTH-1:0] cnt,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tick;
  logic             cnt_zero;

  assign tick     = cen & clkEn;
  assign cnt_zero = (cnt_q == '0);

  // State and count registers; the asynchronous reset clears both at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-count logic. The synchronous clear overrides every
  // state-specific action. At zero the count is held rather than
  // decremented, so the run ends in DONE instead of wrapping to all-ones.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst_cu) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = COUNT;
            cnt_d   = ld_val;
          end
        end
        COUNT: begin
          if (tick) begin
            if (cnt_zero) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are pure register / state decode; only bo combines the count
  // with the state.
  assign cnt  = cnt_q;
  assign bo   = (state_q == COUNT) && cnt_zero;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_down_counter_ctrl
//
// Self-checking bench for down_counter_ctrl (WIDTH = 4). A table of input /
// expected-output records covers the basic runs, hand-written sequences
// cover the multi-cycle corner cases (clkEn gating, abort, asynchronous
// reset, back-to-back runs), and a randomized phase is checked against a
// reference model that tracks the number of ticks remaining in a run.
// ---------------------------------------------------------------------------
module tb_down_counter_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         rst_cu;
  logic         start;
  logic [W-1:0] ld_val;
  logic         cen;
  logic         clkEn;
  logic [W-1:0] cnt;
  logic         bo;
  logic         busy;
  logic         done;

  int total;
  int bad;

  // Reference model: m_rem is the number of ticks still needed to finish
  // the run (0 when not counting); m_done marks the completion cycle.
  int m_rem;
  bit m_done;

  typedef struct {
    logic         rst_cu;
    logic         start;
    logic [W-1:0] ld_val;
    logic         cen;
    logic         clk_en;
    logic [W-1:0] exp_cnt;
    logic         exp_bo;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t vecs[$];

  down_counter_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .rst_cu (rst_cu),
    .start  (start),
    .ld_val (ld_val),
    .cen    (cen),
    .clkEn  (clkEn),
    .cnt    (cnt),
    .bo     (bo),
    .busy   (busy),
    .done   (done)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the reference model by one rising edge with the given inputs.
  task automatic modelStep(input logic rc, input logic st, input logic [W-1:0] ld,
                           input logic ce, input logic ke);
    if (rc) begin
      m_rem  = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      if (ce && ke) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_done = 1'b1;
      end
    end else if (st) begin
      m_rem = int'(ld) + 1;
    end
  endtask

  // Drive inputs, let one rising edge pass, update the model, then move
  // 1 time unit past the edge so outputs are sampled away from it.
  task automatic applyStimulus(input logic rc, input logic st, input logic [W-1:0] ld,
                               input logic ce, input logic ke);
    rst_cu = rc;
    start  = st;
    ld_val = ld;
    cen    = ce;
    clkEn  = ke;
    @(posedge clk);
    modelStep(rc, st, ld, ce, ke);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] e_cnt,
                             input logic e_bo, input logic e_busy, input logic e_done);
    total++;
    if (cnt !== e_cnt || bo !== e_bo || busy !== e_busy || done !== e_done) begin
      bad++;
      $display("[TB] FAIL %s: got cnt=%0d bo=%0b busy=%0b done=%0b, required cnt=%0d bo=%0b busy=%0b done=%0b",
               name, cnt, bo, busy, done, e_cnt, e_bo, e_busy, e_done);
    end
  endtask

  task automatic checkModel(input string name);
    logic [W-1:0] e_cnt;
    e_cnt = (m_rem > 0) ? W'(m_rem - 1) : '0;
    checkOutput(name, e_cnt, (m_rem == 1), (m_rem > 0) || m_done, m_done);
  endtask

  function automatic vec_t mk(input logic rc, input logic st, input logic [W-1:0] ld,
                              input logic ce, input logic ke, input logic [W-1:0] ec,
                              input logic eb, input logic ebu, input logic ed);
    vec_t v;
    v.rst_cu = rc;   v.start = st;   v.ld_val = ld;  v.cen = ce;  v.clk_en = ke;
    v.exp_cnt = ec;  v.exp_bo = eb;  v.exp_busy = ebu; v.exp_done = ed;
    return v;
  endfunction

  initial begin
    int done_tick;
    int ticks;
    logic [W-1:0] b2b_cnt [10];
    bit           b2b_bo  [10];
    bit           b2b_busy[10];
    bit           b2b_done[10];

    total  = 0;
    bad    = 0;
    m_rem  = 0;
    m_done = 1'b0;

    // Basic run with ld_val = 3: 3,2,1,0(bo), done, idle.
    vecs.push_back(mk(0, 1, 4'd3, 1, 1, 4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'd0, 1, 1, 4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'd0, 1, 1, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'd0, 1, 1, 4'd0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0));
    // ld_val = 0: one COUNT cycle at zero with bo, then done, no wrap.
    vecs.push_back(mk(0, 1, 4'd0, 1, 1, 4'd0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0));
    // start during COUNT and DONE is ignored and not queued.
    vecs.push_back(mk(0, 1, 4'd1, 1, 1, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4'd9, 1, 1, 4'd0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 4'd5, 1, 1, 4'd0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'd5, 1, 1, 4'd0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd5, 1, 1, 4'd0, 0, 0, 0));
    // No tick holds the count; rst_cu beats a pending start.
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'd7, 0, 1, 4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'd7, 1, 0, 4'd2, 0, 1, 0));
    vecs.push_back(mk(1, 1, 4'd7, 1, 1, 4'd0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0));

    rst    = 1'b0;
    rst_cu = 1'b0;
    start  = 1'b0;
    ld_val = '0;
    cen    = 1'b0;
    clkEn  = 1'b0;

    #2;
    checkOutput("reset_state", 4'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_cu, vecs[i].start, vecs[i].ld_val, vecs[i].cen, vecs[i].clk_en);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_bo,
                  vecs[i].exp_busy, vecs[i].exp_done);
    end

    // clkEn toggling with ld_val = 5: done appears on the sixth tick.
    applyStimulus(0, 1, 4'd5, 1, 0);
    checkOutput("gate_load", 4'd5, 0, 1, 0);
    done_tick = -1;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 4'($urandom_range(0, 15)), 1, (i % 2 == 0));
      if (i % 2 == 0) ticks++;
      checkModel($sformatf("gate_cyc%0d", i));
      if (done) begin
        done_tick = ticks;
        break;
      end
    end
    total++;
    if (done_tick != 6) begin
      bad++;
      $display("[TB] FAIL gate_ticks: done after %0d ticks, required 6", done_tick);
    end
    applyStimulus(0, 0, 4'd0, 1, 1);
    checkOutput("gate_idle", 4'd0, 0, 0, 0);

    // Abort with rst_cu at cnt = 4, then an immediate reload.
    applyStimulus(0, 1, 4'd9, 1, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 4'd0, 1, 1);
    checkOutput("abort_at4", 4'd4, 0, 1, 0);
    applyStimulus(1, 1, 4'd3, 1, 1);
    checkOutput("abort_clear", 4'd0, 0, 0, 0);
    applyStimulus(0, 1, 4'd6, 1, 1);
    checkOutput("abort_reload", 4'd6, 0, 1, 0);
    applyStimulus(1, 0, 4'd0, 0, 0);

    // Asynchronous reset between edges at cnt = 2.
    applyStimulus(0, 1, 4'd7, 1, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 4'd0, 1, 1);
    checkOutput("arst_at2", 4'd2, 0, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_immediate", 4'd0, 0, 0, 0);
    m_rem  = 0;
    m_done = 1'b0;
    rst_cu = 1'b0;
    start  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("arst_held", 4'd0, 0, 0, 0);
    #2;
    rst = 1'b1;
    applyStimulus(0, 1, 4'd3, 1, 1);
    checkOutput("arst_first_start", 4'd3, 0, 1, 0);
    applyStimulus(1, 0, 4'd0, 0, 0);

    // start held high with ld_val = 2: back-to-back runs with one IDLE gap.
    b2b_cnt  = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    b2b_bo   = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    b2b_busy = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    b2b_done = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 4'd2, 1, 1);
      checkOutput($sformatf("b2b%0d", i), b2b_cnt[i], b2b_bo[i], b2b_busy[i], b2b_done[i]);
    end
    applyStimulus(1, 0, 4'd0, 0, 0);
    checkModel("b2b_clear");

    // Randomized phase against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 2) != 0),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0));
      checkModel($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_counter_ctrl.md
DOWN_COUNTER_CTRL -- requirements
Module: down_counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter and load-value width in bits (legal range 2..16).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk SHALL be an input, 1 bit, the sole clock; all state updates occur on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-005 Port rst_cu SHALL be an input, 1 bit, synchronous clear/abort, active-high.
REQ-006 Port start SHALL be an input, 1 bit, load-and-run request, sampled only in IDLE.
REQ-007 Port ld_val SHALL be an input, WIDTH bits, start value captured with start.
REQ-008 Port cen SHALL be an input, 1 bit, count enable.
REQ-009 Port clkEn SHALL be an input, 1 bit, tick qualifier; one counting tick = cen & clkEn high at a rising clk edge.
REQ-010 Port cnt SHALL be an output, WIDTH bits, current count value (registered).
REQ-011 Port bo SHALL be an output, 1 bit, borrow-out: high while in COUNT with cnt == 0 (combinational from registers).
REQ-012 Port busy SHALL be an output, 1 bit, high whenever state != IDLE.
REQ-013 Port done SHALL be an output, 1 bit, one-clock completion pulse, high only in DONE.

Function
REQ-014 The controller SHALL have three states: IDLE, COUNT, DONE.
REQ-015 Priority at each rising edge SHALL be: rst_cu, then the state-specific action below.
REQ-016 rst_cu = 1 SHALL force state IDLE and cnt = 0 at the next edge, from any state, regardless of start, cen or clkEn.
REQ-017 In IDLE with start = 1, the block SHALL load cnt <= ld_val and enter COUNT at the same edge; start = 0 leaves cnt and state unchanged.
REQ-018 In COUNT, on a tick with cnt != 0, the block SHALL set cnt <= cnt - 1 and stay in COUNT.
REQ-019 In COUNT, on a tick with cnt == 0, the block SHALL enter DONE with cnt held at 0; cnt never wraps to all-ones.
REQ-020 In COUNT without a tick (cen = 0 or clkEn = 0), cnt and state SHALL hold.
REQ-021 ld_val = 0 SHALL be legal: COUNT is entered with cnt = 0, bo = 1, and DONE follows the first tick.
REQ-022 With ticks every cycle, the block SHALL spend exactly ld_val + 1 cycles in COUNT, then exactly 1 cycle in DONE.
REQ-023 DONE SHALL last exactly one clock and then return to IDLE unconditionally; cnt stays 0.
REQ-024 start SHALL be ignored outside IDLE, including in DONE; a start in the DONE cycle is not queued.
REQ-025 ld_val SHALL be sampled only at the IDLE+start edge; later changes have no effect on a run in progress.
REQ-026 cnt, busy and done SHALL be driven directly from registers or state decode; only bo combines cnt with the state.

Reset
REQ-027 While rst = 0, the block SHALL immediately force state IDLE, cnt = 0, bo = 0, busy = 0, done = 0, regardless of clk.
REQ-028 After rst is released, the block SHALL accept start at the first rising edge.
REQ-029 Assertion of rst mid-run (COUNT or DONE) SHALL abort the run with no done pulse.

Verification
REQ-030 WIDTH=4, cen=clkEn=1, start pulse with ld_val=3 -> cnt 3,2,1,0 on successive cycles, bo=1 on the cnt=0 cycle, then done=1 for one cycle, then IDLE with busy=0.
REQ-031 ld_val=0, start -> one COUNT cycle with cnt=0, bo=1, then done pulse; no wrap to 4'hF.
REQ-032 ld_val=5, clkEn toggling 1,0,1,0... with cen=1 -> cnt decrements only on clkEn=1 edges; done occurs after 6 ticks.
REQ-033 ld_val=9, rst_cu asserted when cnt=4 -> next edge cnt=0, busy=0, no done pulse; a start on the following cycle reloads normally.
REQ-034 ld_val=7, rst driven low asynchronously between edges at cnt=2 -> outputs go to 0 without a clk edge; no done pulse after release.
REQ-035 start held high continuously with ld_val=2 -> runs back-to-back: DONE cycle, then IDLE for one cycle, then reload (start ignored during COUNT and DONE).
